aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Sequencing controller for one AES encryption core: the round datapath plus the K-bit key-expansion unit.
- Accepts one block/key per valid/ready handshake.
- Holds the key expansion in reset between blocks, then releases it so it emits one 128-bit round key per cycle.
- Drives the round counter and first/last-round strobes to the datapath, and presents completion with output backpressure.

Parameters:
- K, 128: key length in bits; legal values 128, 192, 256; any other value is an elaboration error. Nr = 10 / 12 / 14 respectively.
- CNT_W, 16: width of the completed-block counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  requester has a plaintext block and key ready
- in_ready  output  1  controller accepts a block this cycle
- dp_load  output  1  datapath latches plaintext and key this cycle (= in_valid & in_ready)
- kx_reset  output  1  drives the key-expansion reset; high holds it at its initial state
- rnd_en  output  1  datapath performs a round operation this cycle
- rnd_first  output  1  round 0: AddRoundKey only
- rnd_last  output  1  round Nr: no MixColumns
- round  output  4  current round index 0..Nr
- out_valid  output  1  ciphertext register holds a finished block
- out_ready  input  1  consumer takes the ciphertext
- busy  output  1  a block is in flight or held (state != IDLE)
- blk_count  output  CNT_W  number of completed output handshakes, saturating

Behaviour:
- Reset is synchronous and active-high; clock is clk.
- Reset values: state IDLE, round 0, blk_count 0, out_valid 0, rnd_en/rnd_first/rnd_last 0, kx_reset 1, in_ready 1.
- States: IDLE, ROUND, HOLD.
- IDLE:
  - in_ready=1, kx_reset=1.
  - in_valid → dp_load=1; next state ROUND with round=0.
- ROUND:
  - kx_reset=0, rnd_en=1.
  - rnd_first=(round==0); rnd_last=(round==Nr).
  - round increments by 1 each cycle.
  - At round==Nr, next state HOLD and round returns to 0.
  - in_ready=0; in_valid is ignored; out_ready is ignored.
- HOLD:
  - out_valid=1, kx_reset=1, rnd_en=0.
  - Holds until out_ready.
  - out_ready & !in_valid → IDLE.
  - out_ready & in_valid → back-to-back accept: in_ready=1, dp_load=1, next state ROUND with round 0, no idle bubble.
  - in_ready = out_ready, so the controller never accepts into HOLD while the result is unconsumed.
- Latency:
  - Acceptance at cycle T → round 0 at T+1, round Nr at T+1+Nr, out_valid first high at T+2+Nr.
  - K=128: out_valid at T+12.
  - Throughput with out_ready held high: one block per Nr+2 cycles.
- Key-expansion contract:
  - kx_reset is high in the acceptance cycle, so the expansion starts from its initial state in the cycle after dp_load.
  - Its round-key output is valid and aligned with round 0..Nr while in ROUND.
- blk_count:
  - Increments on out_valid & out_ready.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared only by reset.
- Reset mid-operation (any state):
  - Next cycle is IDLE with all reset values.
  - The in-flight block is discarded with no out_valid.
  - blk_count is cleared.
- Outputs:
  - All outputs except in_ready and dp_load are registered or decoded from state and round only.
  - in_ready and dp_load are combinational from state, in_valid and out_ready.

Test Plan:
- K=128, in_valid pulse at cycle 5 after reset release → dp_load@5; rnd_first@6; round 1..10 @7..16; rnd_last@16; out_valid@17; kx_reset low exactly cycles 6..16.
- K=256, single block → round reaches 14, rnd_last at acceptance+15, out_valid at acceptance+16; K=192 → Nr=12, out_valid at acceptance+14.
- Backpressure: out_ready low for 5 cycles in HOLD with in_valid high → out_valid stays 1, in_ready 0, no dp_load, round stays 0; out_ready rises → same-cycle dp_load, next cycle round 0 with rnd_first.
- Back-to-back: in_valid and out_ready held high, K=128 → dp_load every 12 cycles; blk_count 1,2,3 after three blocks; busy never drops.
- Reset asserted at round 4 → next cycle IDLE, kx_reset=1, in_ready=1, round 0, blk_count 0; no out_valid ever produced for the aborted block.
- CNT_W=2, five completed blocks → blk_count 1,2,3,3,3 (saturates, no wrap).

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Sequencing controller for one AES encryption core: steps the round datapath
// and gates the key-expansion reset so round keys line up with rounds 0..Nr.
module aes_round_ctrl #(
  parameter int K     = 128,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dp_load,
  output logic             kx_reset,
  output logic             rnd_en,
  output logic             rnd_first,
  output logic             rnd_last,
  output logic [3:0]       round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count
);

  localparam logic [3:0] NR = (K == 256) ? 4'd14 : (K == 192) ? 4'd12 : 4'd10;

  generate
    if (K != 128 && K != 192 && K != 256) begin : g_bad_k
      $error("aes_round_ctrl: K must be 128, 192 or 256");
    end
  endgenerate

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0] state;

  // Accepting in HOLD only when the finished block leaves the same cycle gives
  // back-to-back blocks with no idle bubble.
  always_comb begin
    in_ready = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
    dp_load  = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      round <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          round <= 4'd0;
          if (dp_load) state <= S_ROUND;
        end
        S_ROUND: begin
          if (round == NR) begin
            state <= S_HOLD;
            round <= 4'd0;
          end else begin
            round <= round + 4'd1;
          end
        end
        S_HOLD: begin
          round <= 4'd0;
          if (out_ready) state <= in_valid ? S_ROUND : S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          round <= 4'd0;
        end
      endcase
    end
  end

  // Completed-block counter saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_count <= '0;
    end else if ((state == S_HOLD) && out_ready && (blk_count != {CNT_W{1'b1}})) begin
      blk_count <= blk_count + CNT_W'(1);
    end
  end

  assign rnd_en    = (state == S_ROUND);
  assign rnd_first = rnd_en && (round == 4'd0);
  assign rnd_last  = rnd_en && (round == NR);
  assign kx_reset  = !rnd_en;
  assign out_valid = (state == S_HOLD);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: three key sizes plus a 2-bit counter
// variant all share one stimulus stream.
module tb_aes_round_ctrl;

  logic clk;
  logic reset;
  logic in_valid;
  logic out_ready;

  int compared;
  int mismatched;

  logic       a_in_ready, a_dp_load, a_kx_reset, a_rnd_en, a_rnd_first, a_rnd_last;
  logic       a_out_valid, a_busy;
  logic [3:0] a_round;
  logic [15:0] a_blk_count;

  logic       b_in_ready, b_dp_load, b_kx_reset, b_rnd_en, b_rnd_first, b_rnd_last;
  logic       b_out_valid, b_busy;
  logic [3:0] b_round;
  logic [15:0] b_blk_count;

  logic       c_in_ready, c_dp_load, c_kx_reset, c_rnd_en, c_rnd_first, c_rnd_last;
  logic       c_out_valid, c_busy;
  logic [3:0] c_round;
  logic [15:0] c_blk_count;

  logic       d_in_ready, d_dp_load, d_kx_reset, d_rnd_en, d_rnd_first, d_rnd_last;
  logic       d_out_valid, d_busy;
  logic [3:0] d_round;
  logic [1:0] d_blk_count;

  aes_round_ctrl #(.K(128), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .dp_load(a_dp_load), .kx_reset(a_kx_reset), .rnd_en(a_rnd_en),
    .rnd_first(a_rnd_first), .rnd_last(a_rnd_last), .round(a_round),
    .out_valid(a_out_valid), .out_ready(out_ready), .busy(a_busy),
    .blk_count(a_blk_count)
  );

  aes_round_ctrl #(.K(192), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .dp_load(b_dp_load), .kx_reset(b_kx_reset), .rnd_en(b_rnd_en),
    .rnd_first(b_rnd_first), .rnd_last(b_rnd_last), .round(b_round),
    .out_valid(b_out_valid), .out_ready(out_ready), .busy(b_busy),
    .blk_count(b_blk_count)
  );

  aes_round_ctrl #(.K(256), .CNT_W(16)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
    .dp_load(c_dp_load), .kx_reset(c_kx_reset), .rnd_en(c_rnd_en),
    .rnd_first(c_rnd_first), .rnd_last(c_rnd_last), .round(c_round),
    .out_valid(c_out_valid), .out_ready(out_ready), .busy(c_busy),
    .blk_count(c_blk_count)
  );

  aes_round_ctrl #(.K(128), .CNT_W(2)) dut_d (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d_in_ready),
    .dp_load(d_dp_load), .kx_reset(d_kx_reset), .rnd_en(d_rnd_en),
    .rnd_first(d_rnd_first), .rnd_last(d_rnd_last), .round(d_round),
    .out_valid(d_out_valid), .out_ready(out_ready), .busy(d_busy),
    .blk_count(d_blk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic ordy);
    in_valid  = iv;
    out_ready = ordy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    repeat (3) tick();

    checkOutput("rst_round",     32'(a_round),     32'd0);
    checkOutput("rst_blk_count", 32'(a_blk_count), 32'd0);
    checkOutput("rst_out_valid", 32'(a_out_valid), 32'd0);
    checkOutput("rst_rnd_en",    32'(a_rnd_en),    32'd0);
    checkOutput("rst_rnd_first", 32'(a_rnd_first), 32'd0);
    checkOutput("rst_rnd_last",  32'(a_rnd_last),  32'd0);
    checkOutput("rst_kx_reset",  32'(a_kx_reset),  32'd1);
    checkOutput("rst_in_ready",  32'(a_in_ready),  32'd1);
    checkOutput("rst_busy",      32'(a_busy),      32'd0);
    reset = 1'b0;

    // Single block into all key sizes; out_ready held low so results wait in HOLD.
    repeat (4) tick();
    applyStimulus(1'b1, 1'b0);
    checkOutput("acc_dp_load_128",  32'(a_dp_load),  32'd1);
    checkOutput("acc_dp_load_192",  32'(b_dp_load),  32'd1);
    checkOutput("acc_dp_load_256",  32'(c_dp_load),  32'd1);
    checkOutput("acc_kx_reset_128", 32'(a_kx_reset), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0);
    for (int j = 1; j <= 18; j++) begin
      checkOutput("blk_round_128",     32'(a_round),     (j <= 11) ? 32'(j - 1) : 32'd0);
      checkOutput("blk_rnd_en_128",    32'(a_rnd_en),    (j <= 11) ? 32'd1 : 32'd0);
      checkOutput("blk_rnd_first_128", 32'(a_rnd_first), (j == 1) ? 32'd1 : 32'd0);
      checkOutput("blk_rnd_last_128",  32'(a_rnd_last),  (j == 11) ? 32'd1 : 32'd0);
      checkOutput("blk_kx_reset_128",  32'(a_kx_reset),  (j <= 11) ? 32'd0 : 32'd1);
      checkOutput("blk_out_valid_128", 32'(a_out_valid), (j <= 11) ? 32'd0 : 32'd1);
      checkOutput("blk_in_ready_128",  32'(a_in_ready),  32'd0);
      checkOutput("blk_busy_128",      32'(a_busy),      32'd1);
      checkOutput("blk_round_192",     32'(b_round),     (j <= 13) ? 32'(j - 1) : 32'd0);
      checkOutput("blk_rnd_last_192",  32'(b_rnd_last),  (j == 13) ? 32'd1 : 32'd0);
      checkOutput("blk_out_valid_192", 32'(b_out_valid), (j <= 13) ? 32'd0 : 32'd1);
      checkOutput("blk_round_256",     32'(c_round),     (j <= 15) ? 32'(j - 1) : 32'd0);
      checkOutput("blk_rnd_last_256",  32'(c_rnd_last),  (j == 15) ? 32'd1 : 32'd0);
      checkOutput("blk_out_valid_256", 32'(c_out_valid), (j <= 15) ? 32'd0 : 32'd1);
      if (j < 18) tick();
    end

    // Backpressure: a new block waits while the finished one is unconsumed.
    for (int i = 0; i < 5; i++) begin
      tick();
      applyStimulus(1'b1, 1'b0);
      checkOutput("bp_out_valid", 32'(a_out_valid), 32'd1);
      checkOutput("bp_in_ready",  32'(a_in_ready),  32'd0);
      checkOutput("bp_dp_load",   32'(a_dp_load),   32'd0);
      checkOutput("bp_round",     32'(a_round),     32'd0);
      checkOutput("bp_blk_count", 32'(a_blk_count), 32'd0);
    end
    tick();
    applyStimulus(1'b1, 1'b1);
    checkOutput("bp_release_dp_load",  32'(a_dp_load),  32'd1);
    checkOutput("bp_release_in_ready", 32'(a_in_ready), 32'd1);

    // Back-to-back blocks with both sides always ready.
    tick();
    applyStimulus(1'b1, 1'b1);
    checkOutput("b2b_rnd_first", 32'(a_rnd_first), 32'd1);
    checkOutput("b2b_out_valid", 32'(a_out_valid), 32'd0);
    for (int k = 1; k <= 48; k++) begin
      if (k > 1) begin
        tick();
        applyStimulus(1'b1, 1'b1);
      end
      checkOutput("b2b_busy",      32'(a_busy),      32'd1);
      checkOutput("b2b_dp_load",   32'(a_dp_load),   (k % 12 == 0) ? 32'd1 : 32'd0);
      checkOutput("b2b_out_valid", 32'(a_out_valid), (k % 12 == 0) ? 32'd1 : 32'd0);
      checkOutput("b2b_rnd_last",  32'(a_rnd_last),  (k % 12 == 11) ? 32'd1 : 32'd0);
      checkOutput("b2b_round",     32'(a_round),     (k % 12 == 0) ? 32'd0 : 32'((k - 1) % 12));
      checkOutput("b2b_blk_count", 32'(a_blk_count), 32'(1 + (k - 1) / 12));
      checkOutput("sat_blk_count", 32'(d_blk_count), ((1 + (k - 1) / 12) > 3) ? 32'd3 : 32'(1 + (k - 1) / 12));
    end
    tick();
    applyStimulus(1'b0, 1'b1);
    checkOutput("b2b_blk_count_final", 32'(a_blk_count), 32'd5);
    checkOutput("sat_blk_count_final", 32'(d_blk_count), 32'd3);

    // Abort the block in flight at round 4.
    repeat (4) tick();
    checkOutput("abort_round_before", 32'(a_round), 32'd4);
    reset = 1'b1;
    tick();
    checkOutput("abort_kx_reset",  32'(a_kx_reset),  32'd1);
    checkOutput("abort_in_ready",  32'(a_in_ready),  32'd1);
    checkOutput("abort_round",     32'(a_round),     32'd0);
    checkOutput("abort_blk_count", 32'(a_blk_count), 32'd0);
    checkOutput("abort_busy",      32'(a_busy),      32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("abort_no_out_valid", 32'(a_out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
